// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: data width, opcode
// constants and the state encoding used by stall-capable stages.
package pipeline_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: registers the execute bundle, runs LW/SW on a
// req/ack data-memory bus with a timeout, and presents a registered
// write-back bundle.
//
// state  | meaning
// IDLE   | ready; accepts a new bundle each cycle
// ACCESS | dmem request outstanding; upstream stalled
module mem_stage #(
  parameter int DATA_W       = 32,
  parameter int DMEM_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              reg_write,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [5:0]        wb_opcode,
  output logic              mem_err
);

  import pipeline_pkg::state_t;
  import pipeline_pkg::IDLE;
  import pipeline_pkg::ACCESS;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DMEM_TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic [TO_W-1:0] to_cnt;

  logic [4:0] lat_rd;
  logic [5:0] lat_opcode;
  logic       lat_reg_write;

  logic is_mem;
  logic is_bad;
  logic accept;
  logic acc_done;
  logic acc_abort;

  assign is_mem    = mem_read | mem_write;
  assign is_bad    = is_mem && ((alu_result[1:0] != 2'b00) || (mem_read && mem_write));
  assign accept    = in_valid && (state == IDLE);
  assign acc_done  = (state == ACCESS) && dmem_ack;
  assign acc_abort = (state == ACCESS) && !dmem_ack && (to_cnt == TO_LAST);

  // The request is exactly the ACCESS state; both outputs are state-only.
  assign stall_out = (state == ACCESS);
  assign dmem_req  = (state == ACCESS);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; ack takes precedence over the timeout abort.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mem && !is_bad) state_nx = ACCESS;
      ACCESS:  if (acc_done || acc_abort)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Timeout counter: cleared on accept, counts ACCESS cycles without ack.
  always_ff @(posedge clk) begin
    if (reset)                                   to_cnt <= '0;
    else if (accept)                             to_cnt <= '0;
    else if (state == ACCESS && !acc_done && !acc_abort) to_cnt <= to_cnt + 1'b1;
  end

  // Request registers, frozen for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_we       <= 1'b0;
      lat_rd        <= '0;
      lat_opcode    <= '0;
      lat_reg_write <= 1'b0;
    end else if (accept && is_mem && !is_bad) begin
      dmem_addr     <= alu_result;
      dmem_wdata    <= rd_data;
      dmem_we       <= mem_write;
      lat_rd        <= rd;
      lat_opcode    <= opcode;
      lat_reg_write <= reg_write;
    end
  end

  // Write-back bundle: valid and error pulse for one cycle, fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_opcode    <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd;
        wb_reg_write <= reg_write;
        wb_opcode    <= opcode;
      end else if (accept && is_bad) begin
        wb_valid     <= 1'b1;
        wb_data      <= alu_result;
        wb_rd        <= rd;
        wb_reg_write <= 1'b0;
        wb_opcode    <= opcode;
        mem_err      <= 1'b1;
      end else if (acc_done) begin
        wb_valid     <= 1'b1;
        wb_data      <= dmem_we ? dmem_addr : dmem_rdata;
        wb_rd        <= lat_rd;
        wb_reg_write <= dmem_we ? 1'b0 : lat_reg_write;
        wb_opcode    <= lat_opcode;
      end else if (acc_abort) begin
        wb_valid     <= 1'b1;
        wb_rd        <= lat_rd;
        wb_reg_write <= 1'b0;
        wb_opcode    <= lat_opcode;
        mem_err      <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. It registers the execute stage's result bundle, performs LW/SW accesses on a single-port data-memory bus with a req/ack handshake, and presents a registered write-back bundle to the WB stage. Upstream is back-pressured with `stall_out` while an access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- DMEM_TIMEOUT, 255, maximum ACCESS cycles without `dmem_ack` before the access is aborted; must be ≥1.
- TO_W, 8, timeout counter width; must hold DMEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute-stage bundle valid this cycle.
- alu_result  in  DATA_W  ALU result; this is the effective address for LW/SW.
- opcode  in  6  instruction opcode; passed through.
- rd  in  5  destination register.
- mem_read  in  1  load.
- mem_write  in  1  store.
- rd_data  in  DATA_W  store data.
- reg_write  in  1  write-back enable.
- stall_out  out  1  stage busy; upstream holds its bundle.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  word-aligned byte address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  access complete; `dmem_rdata` is valid when this is high.
- dmem_rdata  in  DATA_W  read data.
- wb_valid  out  1  write-back bundle valid.
- wb_data  out  DATA_W  load data or ALU result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register-file write enable.
- wb_opcode  out  6  opcode passthrough.
- mem_err  out  1  one-cycle pulse on a misaligned access, a conflicting read+write, or a timeout.

Behaviour:
- States: IDLE and ACCESS.
- `stall_out` = (state == ACCESS). It is combinational from state only.
- Accept condition: `in_valid` && state == IDLE. While in ACCESS, inputs are ignored; upstream must hold them.
- Non-memory op (mem_read = mem_write = 0), accepted at edge N:
  - At N+1: wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write, wb_opcode=opcode.
  - Latency is 1 cycle; back-to-back throughput is 1 per cycle.
- Error op, accepted at edge N (either condition below):
  - Memory op with alu_result[1:0] ≠ 0 (misaligned).
  - mem_read && mem_write both set.
  - Response: no dmem_req. At N+1: wb_valid=1, wb_reg_write=0, mem_err=1 for one cycle. State stays IDLE.
- Valid memory op, accepted at edge N:
  - Latch addr, wdata, we=mem_write, rd, opcode, reg_write. State → ACCESS and the timeout counter clears to 0.
  - From N+1, dmem_req=1. `dmem_addr`, `dmem_we` and `dmem_wdata` stay constant until the request completes.
- In ACCESS, on the edge where dmem_ack=1 is sampled:
  - Load: wb_data=dmem_rdata, wb_reg_write=latched reg_write.
  - Store: wb_data=latched addr, wb_reg_write=0.
  - In both cases wb_valid=1; state → IDLE.
  - dmem_req is low in the following cycle.
  - Minimum load/store latency from accept to wb_valid is 2 cycles (ack in the first ACCESS cycle).
- Timeout:
  - The counter increments each ACCESS cycle without ack.
  - When counter == DMEM_TIMEOUT-1 and ack=0: abort. Next cycle has dmem_req=0, wb_valid=1, wb_reg_write=0, mem_err=1; state → IDLE.
  - If ack arrives in the same cycle as the timeout, ack wins and no error is raised.
- `dmem_ack` while IDLE is ignored.
- Any edge that completes nothing drives wb_valid=0 next cycle. The wb_* fields other than wb_valid hold their last value; mem_err=0.
- Reset (synchronous, any state, including mid-access):
  - State IDLE, counter 0.
  - All outputs 0: stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_data, wb_rd, wb_reg_write, wb_opcode, mem_err.
  - An in-flight request is dropped: dmem_req is 0 in the cycle after the reset edge, and a later stray ack is ignored.
- Reset has priority over accept and ack in the same cycle.

Decomposition:
- Shared package `pipeline_pkg`:
  - Opcode constants OP_ADD=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011.
  - DATA_W.
  - State enum {IDLE, ACCESS}, shared with future stall-capable stages.
- No sub-module: the FSM, timeout counter and the request and write-back registers stay in `mem_stage`.

Test Plan:
- ADD bundle (alu_result=0x0000_0007, rd=3, reg_write=1) → next cycle wb_valid=1, wb_data=7, wb_rd=3, wb_reg_write=1; stall_out stays 0.
- LW addr 0x10, ack after 3 cycles with rdata 0xDEAD_BEEF → dmem_req high for 3 cycles with addr 0x10 and we=0; stall_out high; then wb_data=0xDEAD_BEEF, wb_reg_write=1; a held next ADD is accepted the cycle after.
- SW addr 0x20, wdata 0x1234, ack in the first ACCESS cycle → dmem_we=1, dmem_wdata=0x1234; wb_valid=1 with wb_reg_write=0 two cycles after accept.
- LW addr 0x13 → no dmem_req; next cycle mem_err=1, wb_valid=1, wb_reg_write=0.
- Timeout: DMEM_TIMEOUT=4, LW with no ack → dmem_req high for exactly 4 cycles, then mem_err=1, wb_valid=1, wb_reg_write=0. Variant with ack on the 4th cycle → normal completion, mem_err=0.
- Reset asserted in the 2nd ACCESS cycle → all outputs 0 the next cycle; a later ack is ignored; a fresh ADD is processed normally.
